// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, responder state type and byte-enable helper.
// S_WAIT exists only when AHB_SRAM_WAIT_EN is defined.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_B  = 3'd0;
  localparam logic [2:0] HSIZE_H  = 3'd1;
  localparam logic [2:0] HSIZE_W  = 3'd2;
  localparam logic [2:0] HSIZE_DW = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RDS,
    S_ERR1,
    S_ERR2
`ifdef AHB_SRAM_WAIT_EN
    , S_WAIT
`endif
  } state_t;

  // Little-endian lane select; data itself is never shifted.
  function automatic logic [7:0] be_from_size(input logic [2:0] hsize, input logic [2:0] addr_lo);
    logic [7:0] be;
    case (hsize)
      HSIZE_B:  be = 8'h01 << addr_lo;
      HSIZE_H:  be = 8'h03 << {addr_lo[2:1], 1'b0};
      HSIZE_W:  be = 8'h0F << {addr_lo[2], 2'b00};
      HSIZE_DW: be = 8'hFF;
      default:  be = 8'h00;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-enable and alignment decode for one AHB address phase.
module ahb_be_gen
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [2:0] addr_lo,
  output logic [7:0] be,
  output logic       align_err
);

  always_comb begin
    be = be_from_size(hsize, addr_lo);
    case (hsize)
      HSIZE_H:  align_err = addr_lo[0];
      HSIZE_W:  align_err = |addr_lo[1:0];
      HSIZE_DW: align_err = |addr_lo;
      default:  align_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite responder fronting a single-port SRAM with 1-clk read latency.
// Define AHB_SRAM_WAIT_EN to add WAIT_CYCLES wait states to every NSEQ beat.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_BYTES   = 65536,
  parameter int          ADDR_W      = 13,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [63:0]       haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [1:0]        htrans,
  input  logic              hmastlock,
  input  logic [63:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [63:0]       hrdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [7:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [63:0]       sram_wdata,
  input  logic [63:0]       sram_rdata
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        be_q, be_d;

  logic [63:0] offset;
  logic [7:0]  be_addr;
  logic        accept, in_range, size_err, align_err, beat_err, rd_req, wr_req;

  assign offset   = haddr - BASE_ADDR;
  assign accept   = hsel & hready & htrans[1];
  assign in_range = (haddr >= BASE_ADDR) && (offset < 64'(MEM_BYTES));
  assign size_err = hsize > HSIZE_DW;
  assign beat_err = accept & (~in_range | size_err | align_err);
  assign rd_req   = accept & ~beat_err & ~hwrite;
  assign wr_req   = accept & ~beat_err & hwrite;

  ahb_be_gen u_be_gen (
    .hsize     (hsize),
    .addr_lo   (haddr[2:0]),
    .be        (be_addr),
    .align_err (align_err)
  );

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, offset[63:ADDR_W+3], offset[2:0]};

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0] wcnt_q, wcnt_d;
  logic       wwr_q, wwr_d;
  logic       nseq;
  assign nseq = htrans == HTRANS_NSEQ;
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = addr_q;
    sram_wdata = hwdata;
`ifdef AHB_SRAM_WAIT_EN
    wcnt_d     = wcnt_q;
    wwr_d      = wwr_q;
`endif

    case (state_q)
      S_WR: begin
        sram_cs = 1'b1;
        sram_we = 1'b1;
        sram_be = be_q;
      end
      S_RD: hrdata = sram_rdata;
      S_RDS: begin
        hreadyout = 1'b0;
        sram_cs   = 1'b1;
        sram_be   = be_q;
        state_d   = S_RD;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: hresp = 1'b1;
`ifdef AHB_SRAM_WAIT_EN
      S_WAIT: begin
        hreadyout = 1'b0;
        if (wcnt_q == 4'd0) begin
          state_d = wwr_q ? S_WR : S_RD;
          if (!wwr_q) begin
            sram_cs = 1'b1;
            sram_be = be_q;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
`endif
      default: ;
    endcase

    // Only completing states (hreadyout=1) take a new address phase.
    if (hreadyout) begin
      if (accept && !beat_err) begin
        addr_d = offset[ADDR_W+2:3];
        be_d   = be_addr;
      end
      if (beat_err) begin
        state_d = S_ERR1;
      end else if (rd_req) begin
`ifdef AHB_SRAM_WAIT_EN
        if (nseq) begin
          state_d = S_WAIT;
          wcnt_d  = 4'(WAIT_CYCLES - 1);
          wwr_d   = 1'b0;
        end else
`endif
        if (state_q == S_WR) begin
          state_d = S_RDS;
        end else begin
          sram_cs   = 1'b1;
          sram_we   = 1'b0;
          sram_be   = be_addr;
          sram_addr = offset[ADDR_W+2:3];
          state_d   = S_RD;
        end
      end else if (wr_req) begin
`ifdef AHB_SRAM_WAIT_EN
        if (nseq) begin
          state_d = S_WAIT;
          wcnt_d  = 4'(WAIT_CYCLES - 1);
          wwr_d   = 1'b1;
        end else
`endif
        state_d = S_WR;
      end else begin
        state_d = S_IDLE;
      end
    end

    // A reset cycle must never touch the SRAM, even mid-burst.
    if (rst) begin
      sram_cs = 1'b0;
      sram_we = 1'b0;
      sram_be = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
`ifdef AHB_SRAM_WAIT_EN
      wcnt_q  <= '0;
      wwr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
`ifdef AHB_SRAM_WAIT_EN
      wcnt_q  <= wcnt_d;
      wwr_q   <= wwr_d;
`endif
    end
  end

endmodule
